// File: rtl/tanh_cordic_pkg.sv
// rtl/tanh_cordic_pkg.sv - shared constants, states and atanh(2^-i) table for tanh_cordic
package tanh_cordic_pkg;

  localparam int FRAC_DEFAULT = 30;
  localparam int ITER_DEFAULT = 28;

  localparam int          EXP_W    = 8;
  localparam int          MANT_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_HROT,
    ST_LDIV,
    ST_PACK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_NORMAL,
    K_BYPASS,
    K_ERROR
  } kind_e;

  // atanh(2^-i) in Q2.30; from i = 10 on the cubic term is below half an LSB
  function automatic logic [31:0] atanh_q30(input logic [4:0] i);
    case (i)
      5'd1:    return 32'd589812981;
      5'd2:    return 32'd274247419;
      5'd3:    return 32'd134923406;
      5'd4:    return 32'd67196451;
      5'd5:    return 32'd33565361;
      5'd6:    return 32'd16778582;
      5'd7:    return 32'd8388779;
      5'd8:    return 32'd4194325;
      5'd9:    return 32'd2097155;
      default: return (i >= 5'd10 && i <= 5'd30) ? (32'd1 << (5'd30 - i)) : 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/tanh_cordic_fp_pack.sv
// rtl/tanh_cordic_fp_pack.sv - leading-one detect and normalise a Q2.FRAC magnitude to IEEE 754
module tanh_cordic_fp_pack
  import tanh_cordic_pkg::*;
#(
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic [31:0] mag,
  input  logic        sign,
  output logic [31:0] result
);

  logic [4:0]        p;
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;

  always_comb begin
    p = '0;
    for (int k = 0; k < 32; k++) begin
      if (mag[k]) p = 5'(k);
    end
    exp_f  = EXP_W'(EXP_BIAS + int'(p) - FRAC);
    // shift the leading one to bit 31, keep the 23 bits beneath it (truncating)
    mant_f = MANT_W'((mag << (5'd31 - p)) >> (31 - MANT_W));
    result = (mag == '0) ? {sign, 31'b0} : {sign, exp_f, mant_f};
  end

endmodule

// File: rtl/tanh_cordic.sv
// rtl/tanh_cordic.sv - sequential float tanh: hyperbolic CORDIC rotation then linear CORDIC divide
module tanh_cordic
  import tanh_cordic_pkg::*;
#(
  parameter int FRAC = FRAC_DEFAULT,
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z_input,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] tanh_output,
  output logic        range_err
);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic               s_q, s_d;
  logic [30:0]        absz_q, absz_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d, q_q, q_d;
  logic [4:0]         i_q, i_d, cnt_q, cnt_d;
  logic               rep_q, rep_d;
  logic [31:0]        out_q, out_d;
  logic               err_q, err_d;

  logic [7:0]         exp_w;
  logic [22:0]        man_w;
  logic [4:0]         lsh;
  logic signed [31:0] x_sh, y_sh, x_lsh, lut_w, step_w;
  logic [31:0]        packed_w;

  assign exp_w       = absz_q[30:23];
  assign man_w       = absz_q[22:0];
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign tanh_output = out_q;
  assign range_err   = err_q;

  assign lsh    = cnt_q + 5'd1;
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;
  assign x_lsh  = x_q >>> lsh;
  assign lut_w  = signed'(atanh_q30(i_q) >> (30 - FRAC));
  assign step_w = signed'(32'd1 << (5'(FRAC) - lsh));

  tanh_cordic_fp_pack #(.FRAC(FRAC)) u_fp_pack (
    .mag    (q_q),
    .sign   (s_q),
    .result (packed_w)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    s_d     = s_q;
    absz_d  = absz_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    q_d     = q_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = z_input[31];
          absz_d  = z_input[30:0];
          err_d   = 1'b0;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        if (exp_w > 8'(EXP_BIAS) || (exp_w == 8'(EXP_BIAS) && man_w != '0)) begin
          kind_d  = K_ERROR;
          state_d = ST_PACK;
        end else if (exp_w <= 8'(EXP_BIAS - 13)) begin
          kind_d  = K_BYPASS;
          state_d = ST_PACK;
        end else begin
          kind_d  = K_NORMAL;
          z_d     = signed'((32'({1'b1, man_w}) << (FRAC - MANT_W)) >> (8'(EXP_BIAS) - exp_w));
          x_d     = signed'(32'd1 << FRAC);
          y_d     = '0;
          i_d     = 5'd1;
          rep_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_HROT;
        end
      end
      ST_HROT: begin
        if (!z_q[31]) begin
          x_d = x_q + y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - lut_w;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + lut_w;
        end
        // hyperbolic CORDIC only converges if iterations 4 and 13 run twice
        if ((i_q == 5'd4 || i_q == 5'd13) && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          i_d   = i_q + 5'd1;
        end
        if (cnt_q == 5'(ITER + 1)) begin
          cnt_d   = '0;
          q_d     = '0;
          state_d = ST_LDIV;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_LDIV: begin
        if (!y_q[31]) begin
          y_d = y_q - x_lsh;
          q_d = q_q + step_w;
        end else begin
          y_d = y_q + x_lsh;
          q_d = q_q - step_w;
        end
        if (cnt_q == 5'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = ST_PACK;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_PACK: begin
        case (kind_q)
          K_ERROR:  out_d = QNAN;
          K_BYPASS: out_d = {s_q, absz_q};
          default:  out_d = packed_w;
        endcase
        err_d   = (kind_q == K_ERROR);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kind_q  <= K_NORMAL;
      s_q     <= 1'b0;
      absz_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      q_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      s_q     <= s_d;
      absz_q  <= absz_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      q_q     <= q_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tanh_cordic.sv
// tb/tb_tanh_cordic.sv - self-checking bench for tanh_cordic against a real-valued tanh model
module tb_tanh_cordic;

  localparam int  ITER     = 28;
  localparam int  NORM_LAT = 2 * ITER + 4;
  localparam int  FAST_LAT = 2;
  localparam real TOL      = 1.0 / 1048576.0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] z_input = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] tanh_output;
  logic        range_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tanh_cordic dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z_input     (z_input),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .tanh_output (tanh_output),
    .range_err   (range_err)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) begin
      r = real'(b[22:0]) / 8388608.0;
      e = -126;
    end else begin
      r = 1.0 + real'(b[22:0]) / 8388608.0;
      e = e - 127;
    end
    for (int k = 0; k < e; k++) r = r * 2.0;
    for (int k = 0; k > e; k--) r = r / 2.0;
    return b[31] ? -r : r;
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // kind: 0 = computed tanh, 1 = passthrough, 2 = range error
  function automatic void ref_model(input logic [31:0] zb, output int kind,
                                    output logic [31:0] eb, output real ev, output int elat);
    real v;
    v  = f2r(zb);
    eb = zb;
    ev = 0.0;
    if (zb[30:23] == 8'hFF || v > 1.0 || v < -1.0) begin
      kind = 2;
      eb   = 32'h7FC0_0000;
      elat = FAST_LAT;
    end else if (zb[30:23] <= 8'd114) begin
      kind = 1;
      elat = FAST_LAT;
    end else begin
      kind = 0;
      ev   = $tanh(v);
      elat = NORM_LAT;
    end
  endfunction

  task automatic run_op(input logic [31:0] zb, output logic [31:0] res,
                        output logic err, output int lat);
    int g;
    res = 'x;
    err = 1'bx;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1;
    z_input  = zb;
    g = 0;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (in_ready === 1'b1) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      g = 0;
      while (out_valid !== 1'b1 && g < 1000) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (out_valid === 1'b1) begin
        lat = g;
        res = tanh_output;
        err = range_err;
      end
      @(posedge clk);
      #1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    n_cmp++;
    if (tanh_output !== 32'h0 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: tanh_output=%h range_err=%b, want 00000000 0", tanh_output, range_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [10];
    logic [31:0] res, eb;
    logic        err;
    int          lat, kind, elat;
    real         ev;
    bit          ok;
    vec = '{32'h3F0CCCCD, 32'h3F800000, 32'hBF400000, 32'h3A83126F, 32'h38D1B717,
            32'h80000000, 32'h3F8CCCCD, 32'h7F800000, 32'h7FC00001, 32'h00000001};
    for (int n = 0; n < 10; n++) begin
      run_op(vec[n], res, err, lat);
      ref_model(vec[n], kind, eb, ev, elat);
      n_cmp++;
      if (lat !== elat || err !== (kind == 2)) begin
        n_bad++;
        $display("FAIL directed_timing z=%h: lat=%0d err=%b, want lat=%0d err=%b",
                 vec[n], lat, err, elat, kind == 2);
      end
      if (kind == 0) ok = (res[31] === vec[n][31]) && (rabs(f2r(res) - ev) <= TOL);
      else           ok = (res === eb);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL directed_value z=%h: got %h (%.9f), want %h (%.9f)",
                 vec[n], res, f2r(res), eb, ev);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] zb, res, eb;
    logic [7:0]  ex;
    logic [22:0] man;
    logic        err;
    int          lat, kind, elat, sel;
    real         ev;
    bit          ok;
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(9, 0));
      man = 23'($urandom);
      if (sel < 6) begin
        ex = 8'($urandom_range(126, 115));
      end else if (sel < 8) begin
        ex = 8'($urandom_range(114, 0));
      end else begin
        ex = 8'($urandom_range(255, 127));
        if (ex == 8'd127 && man == '0) man = 23'd1;
      end
      zb = {1'($urandom_range(1, 0)), ex, man};
      run_op(zb, res, err, lat);
      ref_model(zb, kind, eb, ev, elat);
      n_cmp++;
      if (lat !== elat || err !== (kind == 2)) begin
        n_bad++;
        $display("FAIL random_timing z=%h: lat=%0d err=%b, want lat=%0d err=%b",
                 zb, lat, err, elat, kind == 2);
      end
      if (kind == 0) ok = (res[31] === zb[31]) && (rabs(f2r(res) - ev) <= TOL);
      else           ok = (res === eb);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL random_value z=%h: got %h (%.9f), want %h (%.9f)", zb, res, f2r(res), eb, ev);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, res2;
    logic        err, err2;
    int          lat, lat2;
    bit          stable, ir_low;
    out_ready = 1'b0;
    run_op(32'h3F0CCCCD, res, err, lat);
    n_cmp++;
    if (lat !== NORM_LAT || rabs(f2r(res) - $tanh(f2r(32'h3F0CCCCD))) > TOL) begin
      n_bad++;
      $display("FAIL bp_first_result: lat=%0d res=%h, want lat=%0d tanh(0.55)", lat, res, NORM_LAT);
    end
    stable = 1'b1;
    ir_low = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 4);
      z_input  = 32'h7F800000;
      if (out_valid !== 1'b1 || tanh_output !== res || range_err !== err) stable = 1'b0;
      if (in_ready !== 1'b0) ir_low = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (!stable || !ir_low) begin
      n_bad++;
      $display("FAIL bp_hold: stable=%b in_ready_low=%b, want 1 1", stable, ir_low);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    run_op(32'h3F800000, res2, err2, lat2);
    n_cmp++;
    if (lat2 !== NORM_LAT || err2 !== 1'b0 || rabs(f2r(res2) - $tanh(1.0)) > TOL) begin
      n_bad++;
      $display("FAIL bp_next_op: lat=%0d err=%b res=%h, want lat=%0d err=0 tanh(1.0)",
               lat2, err2, res2, NORM_LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        err;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1;
    z_input  = 32'h3F0CCCCD;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_busy: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || tanh_output !== 32'h0 || in_ready !== 1'b1 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_abort: out_valid=%b tanh_output=%h in_ready=%b range_err=%b, want 0 00000000 1 0",
               out_valid, tanh_output, in_ready, range_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h3F0CCCCD, res, err, lat);
    n_cmp++;
    if (lat !== NORM_LAT || err !== 1'b0 || rabs(f2r(res) - $tanh(f2r(32'h3F0CCCCD))) > TOL) begin
      n_bad++;
      $display("FAIL rst_mid_recover: lat=%0d err=%b res=%h, want lat=%0d err=0 tanh(0.55)",
               lat, err, res, NORM_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
